// File: rtl/mc6809_intc.sv
// Interrupt controller answering the 6809 IRQ/FIRQ/NMI protocol.
// Eight edge-triggered sources and a memory-mapped register window.
module mc6809_intc #(
  parameter logic [15:0] BASE    = 16'hFF80,
  parameter int unsigned NMI_LEN = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CYC,
  input  logic [15:0] ADDR,
  input  logic        RnW,
  input  logic        BS,
  input  logic        BA,
  input  logic [7:0]  DIN,
  output logic [7:0]  DOUT,
  output logic        DSEL,
  input  logic [7:0]  SRC,
  input  logic        NMI_REQ,
  output logic        nIRQ,
  output logic        nFIRQ,
  output logic        nNMI,
  output logic [15:0] Intvector,
  output logic [1:0]  ack_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, HI_IRQ = 2'd1, HI_FIRQ = 2'd2} ack_t;

  localparam logic [7:0] NMI_LOAD = NMI_LEN[7:0];

  ack_t        state, state_nx;
  logic [7:0]  src_s1, src_s2, src_s3;
  logic        nmi_s1, nmi_s2, nmi_s3;
  logic [7:0]  pend, mask, fsel, vbh, act;
  logic [3:0]  vbl_hi;
  logic [2:0]  id_q;
  logic        valid_q;
  logic [7:0]  nmi_cnt;

  logic [15:0] off;
  logic [2:0]  sel_off;
  logic        win, wr, fetch;
  logic [7:0]  irq_v, firq_v, vec_set, edges, w1c, swset, clr_mask;
  logic [2:0]  id_c;
  logic        ack_ld, ack_clr, is_firq;

  assign off     = ADDR - BASE;
  assign win     = (off < 16'd8);
  assign sel_off = off[2:0];
  assign wr      = CYC & ~RnW & win;
  assign DSEL    = CYC & RnW & win;
  assign fetch   = CYC & BS & ~BA;

  assign irq_v   = pend & mask & ~fsel;
  assign firq_v  = pend & mask & fsel;
  assign edges   = src_s2 & ~src_s3;
  assign w1c     = (wr && sel_off == 3'd0) ? DIN : 8'h00;
  assign swset   = (wr && sel_off == 3'd6) ? DIN : 8'h00;
  assign is_firq = (ADDR == 16'hFFF6);
  assign vec_set = is_firq ? firq_v : irq_v;
  assign clr_mask = ack_clr ? (8'h01 << id_q) : 8'h00;
  assign ack_state = state;

  always_comb begin
    DOUT = 8'h00;
    if (DSEL) begin
      case (sel_off)
        3'd0:    DOUT = pend;
        3'd1:    DOUT = mask;
        3'd2:    DOUT = fsel;
        3'd3:    DOUT = vbh;
        3'd4:    DOUT = {vbl_hi, 4'h0};
        3'd5:    DOUT = act;
        default: DOUT = 8'h00;
      endcase
    end
  end

  // Lowest index wins; an empty set reports id 7 (spurious ack).
  always_comb begin
    id_c = 3'd7;
    for (int i = 7; i >= 0; i--) begin
      if (vec_set[i]) id_c = i[2:0];
    end
  end

  always_comb begin
    state_nx = state;
    ack_ld   = 1'b0;
    ack_clr  = 1'b0;
    case (state)
      IDLE: begin
        if (fetch && RnW && ADDR == 16'hFFF8) begin
          state_nx = HI_IRQ;
          ack_ld   = 1'b1;
        end else if (fetch && RnW && ADDR == 16'hFFF6) begin
          state_nx = HI_FIRQ;
          ack_ld   = 1'b1;
        end
      end
      HI_IRQ: begin
        if (CYC) begin
          state_nx = IDLE;
          ack_clr  = fetch && ADDR == 16'hFFF9 && valid_q;
        end
      end
      HI_FIRQ: begin
        if (CYC) begin
          state_nx = IDLE;
          ack_clr  = fetch && ADDR == 16'hFFF7 && valid_q;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      src_s1 <= 8'h00; src_s2 <= 8'h00; src_s3 <= 8'h00;
      nmi_s1 <= 1'b0;  nmi_s2 <= 1'b0;  nmi_s3 <= 1'b0;
    end else begin
      src_s1 <= SRC;     src_s2 <= src_s1; src_s3 <= src_s2;
      nmi_s1 <= NMI_REQ; nmi_s2 <= nmi_s1; nmi_s3 <= nmi_s2;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pend      <= 8'h00;
      mask      <= 8'h00;
      fsel      <= 8'h00;
      vbh       <= 8'hFF;
      vbl_hi    <= 4'hF;
      act       <= 8'h00;
      id_q      <= 3'd7;
      valid_q   <= 1'b0;
      nIRQ      <= 1'b1;
      nFIRQ     <= 1'b1;
      Intvector <= 16'hFFF0;
    end else begin
      // Set terms are OR-ed last so they override any clear of the same bit.
      pend  <= (pend & ~w1c & ~clr_mask) | edges | swset;
      nIRQ  <= ~|irq_v;
      nFIRQ <= ~|firq_v;
      if (wr) begin
        case (sel_off)
          3'd1:    mask   <= DIN;
          3'd2:    fsel   <= DIN;
          3'd3:    vbh    <= DIN;
          3'd4:    vbl_hi <= DIN[7:4];
          default: ;
        endcase
      end
      if (ack_ld) begin
        Intvector <= {vbh, vbl_hi, id_c, 1'b0};
        act       <= {|vec_set, is_firq, 3'b000, id_c};
        id_q      <= id_c;
        valid_q   <= |vec_set;
      end
    end
  end

  // A new edge reloads the counter, so a retrigger stretches the pulse.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      nmi_cnt <= 8'h00;
      nNMI    <= 1'b1;
    end else begin
      nNMI <= (nmi_cnt == 8'h00);
      if (nmi_s2 && !nmi_s3)       nmi_cnt <= NMI_LOAD;
      else if (nmi_cnt != 8'h00)   nmi_cnt <= nmi_cnt - 8'h01;
    end
  end

endmodule

// File: tb/tb_mc6809_intc.sv
// Bench for mc6809_intc: register table, protocol sequences, and a
// randomized run against a cycle-level behavioural model.
module tb_mc6809_intc;

  localparam logic [15:0] BASE = 16'hFF80;
  localparam int NMI_LEN = 8;
  localparam int NCYC = 600;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        CYC, RnW, BS, BA, NMI_REQ;
  logic [15:0] ADDR;
  logic [7:0]  DIN, SRC;
  logic [7:0]  DOUT;
  logic        DSEL, nIRQ, nFIRQ, nNMI;
  logic [15:0] Intvector;
  logic [1:0]  ack_state;

  int total = 0;
  int bad = 0;

  mc6809_intc #(.BASE(BASE), .NMI_LEN(NMI_LEN)) dut (
    .CLK(CLK), .RESET(RESET), .CYC(CYC), .ADDR(ADDR), .RnW(RnW),
    .BS(BS), .BA(BA), .DIN(DIN), .DOUT(DOUT), .DSEL(DSEL),
    .SRC(SRC), .NMI_REQ(NMI_REQ), .nIRQ(nIRQ), .nFIRQ(nFIRQ),
    .nNMI(nNMI), .Intvector(Intvector), .ack_state(ack_state)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [2:0] off;
    logic [7:0] wdata;
    logic [7:0] rdata;
  } vec_t;

  vec_t tbl[8];

  // Behavioural model state for the randomized run.
  logic [7:0]  m_pend, m_mask, m_fsel, m_vbh, m_vbl, m_act;
  logic [15:0] m_ivec;
  logic        m_nirq, m_nfirq, m_nnmi;
  int          m_hold;
  int          m_hid;
  logic        m_hval;
  int          last_load;
  logic [7:0]  src_at[0:NCYC];
  logic        nmi_at[0:NCYC];

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic bus_idle();
    CYC = 1'b0; RnW = 1'b1; BS = 1'b0; BA = 1'b0; ADDR = 16'h0000; DIN = 8'h00;
  endtask

  task automatic do_reset();
    bus_idle();
    SRC = 8'h00; NMI_REQ = 1'b0; RESET = 1'b1;
    step(); step();
    RESET = 1'b0;
  endtask

  task automatic bus_write(input logic [2:0] off, input logic [7:0] d);
    CYC = 1'b1; RnW = 1'b0; BS = 1'b0; BA = 1'b0; ADDR = BASE + 16'(off); DIN = d;
    step();
    bus_idle();
  endtask

  task automatic fetch(input logic [15:0] a);
    CYC = 1'b1; RnW = 1'b1; BS = 1'b1; BA = 1'b0; ADDR = a;
    step();
    bus_idle();
  endtask

  // Combinational read inside the current cycle; no clock edge sees it.
  task automatic peek(input string name, input logic [2:0] off, input logic [7:0] exp);
    CYC = 1'b1; RnW = 1'b1; BS = 1'b0; BA = 1'b0; ADDR = BASE + 16'(off);
    #1;
    check(name, {8'h00, DOUT}, {8'h00, exp});
    bus_idle();
  endtask

  function automatic logic [7:0] sat(int i);
    return (i < 1) ? 8'h00 : src_at[i];
  endfunction

  function automatic logic nat(int i);
    return (i < 1) ? 1'b0 : nmi_at[i];
  endfunction

  function automatic logic [7:0] mread(logic [2:0] off);
    case (off)
      3'd0:    return m_pend;
      3'd1:    return m_mask;
      3'd2:    return m_fsel;
      3'd3:    return m_vbh;
      3'd4:    return m_vbl;
      3'd5:    return m_act;
      default: return 8'h00;
    endcase
  endfunction

  // One clock edge of the model, using the bus inputs currently driven.
  task automatic model_edge(input int c);
    logic [7:0] irqv, firqv, w1c, sws, clr, v;
    logic [2:0] woff;
    logic       in_win, ftch, found;
    int         id;
    irqv  = m_pend & m_mask & ~m_fsel;
    firqv = m_pend & m_mask & m_fsel;
    w1c = 8'h00; sws = 8'h00; clr = 8'h00;
    in_win = CYC && ADDR >= BASE && ADDR <= BASE + 16'd7;
    woff = 3'(ADDR - BASE);
    if (in_win && !RnW) begin
      case (woff)
        3'd0: w1c = DIN;
        3'd1: m_mask = DIN;
        3'd2: m_fsel = DIN;
        3'd3: m_vbh = DIN;
        3'd4: m_vbl = {DIN[7:4], 4'h0};
        3'd6: sws = DIN;
        default: ;
      endcase
    end
    ftch = CYC && BS && !BA;
    if (m_hold == 0) begin
      if (ftch && RnW && (ADDR == 16'hFFF8 || ADDR == 16'hFFF6)) begin
        v = (ADDR == 16'hFFF8) ? irqv : firqv;
        id = 7; found = 1'b0;
        for (int i = 0; i < 8; i++) begin
          if (!found && v[i]) begin id = i; found = 1'b1; end
        end
        m_ivec = {m_vbh, m_vbl[7:4], 3'(id), 1'b0};
        m_act  = {found, ADDR == 16'hFFF6, 3'b000, 3'(id)};
        m_hold = (ADDR == 16'hFFF8) ? 1 : 2;
        m_hid  = id;
        m_hval = found;
      end
    end else if (CYC) begin
      if (ftch && ADDR == ((m_hold == 1) ? 16'hFFF9 : 16'hFFF7) && m_hval)
        clr = 8'h01 << m_hid;
      m_hold = 0;
    end
    m_pend  = (m_pend & ~w1c & ~clr) | (sat(c - 2) & ~sat(c - 3)) | sws;
    m_nirq  = (irqv == 8'h00);
    m_nfirq = (firqv == 8'h00);
    m_nnmi  = !(last_load > 0 && c > last_load && c <= last_load + NMI_LEN);
    if (nat(c - 2) && !nat(c - 3)) last_load = c;
  endtask

  initial begin
    int op, prev_op, idx;
    logic [2:0] roff;
    bus_idle();
    RESET = 1'b1; SRC = 8'h00; NMI_REQ = 1'b0;

    // Reset state
    do_reset();
    check("rst_nirq", 16'(nIRQ), 16'h1);
    check("rst_nfirq", 16'(nFIRQ), 16'h1);
    check("rst_nnmi", 16'(nNMI), 16'h1);
    check("rst_vec", Intvector, 16'hFFF0);
    check("rst_dsel", 16'(DSEL), 16'h0);
    check("rst_dout", 16'(DOUT), 16'h0);
    peek("rst_pend", 3'd0, 8'h00);
    peek("rst_vbh", 3'd3, 8'hFF);
    peek("rst_vbl", 3'd4, 8'hF0);
    peek("rst_act", 3'd5, 8'h00);

    // Register write/read table
    tbl[0] = '{3'd1, 8'hA5, 8'hA5};
    tbl[1] = '{3'd2, 8'h3C, 8'h3C};
    tbl[2] = '{3'd3, 8'h12, 8'h12};
    tbl[3] = '{3'd4, 8'h3F, 8'h30};
    tbl[4] = '{3'd5, 8'h55, 8'h00};
    tbl[5] = '{3'd7, 8'hFF, 8'h00};
    tbl[6] = '{3'd6, 8'h00, 8'h00};
    tbl[7] = '{3'd0, 8'h00, 8'h00};
    for (int i = 0; i < 8; i++) begin
      bus_write(tbl[i].off, tbl[i].wdata);
      peek($sformatf("tbl%0d", i), tbl[i].off, tbl[i].rdata);
    end

    // Single IRQ source through a full acknowledge
    do_reset();
    bus_write(3'd1, 8'hFF);
    SRC = 8'h08;
    step(); step();
    peek("s1_pend_early", 3'd0, 8'h00);
    step();
    peek("s1_pend", 3'd0, 8'h08);
    check("s1_nirq_hi", 16'(nIRQ), 16'h1);
    step();
    check("s1_nirq_lo", 16'(nIRQ), 16'h0);
    SRC = 8'h00;
    fetch(16'hFFF8);
    check("s1_vec", Intvector, 16'hFFF6);
    peek("s1_act", 3'd5, 8'h83);
    fetch(16'hFFF9);
    peek("s1_pend_clr", 3'd0, 8'h00);
    check("s1_nirq_hold", 16'(nIRQ), 16'h0);
    step();
    check("s1_nirq_rel", 16'(nIRQ), 16'h1);

    // Simultaneous FIRQ and IRQ sources
    do_reset();
    bus_write(3'd1, 8'hFF);
    bus_write(3'd2, 8'h04);
    SRC = 8'h24;
    step(); step(); step(); step();
    check("s2_nfirq", 16'(nFIRQ), 16'h0);
    check("s2_nirq", 16'(nIRQ), 16'h0);
    SRC = 8'h00;
    fetch(16'hFFF6);
    check("s2_fvec", Intvector, 16'hFFF4);
    peek("s2_fact", 3'd5, 8'hC2);
    fetch(16'hFFF7);
    fetch(16'hFFF8);
    check("s2_ivec", Intvector, 16'hFFFA);
    peek("s2_iact", 3'd5, 8'h85);
    fetch(16'hFFF9);
    step();
    check("s2_nirq_rel", 16'(nIRQ), 16'h1);
    check("s2_nfirq_rel", 16'(nFIRQ), 16'h1);
    peek("s2_pend", 3'd0, 8'h00);

    // Vector base, W1C, and set-over-clear priority
    do_reset();
    bus_write(3'd3, 8'h12);
    bus_write(3'd4, 8'h30);
    bus_write(3'd6, 8'h01);
    bus_write(3'd1, 8'h01);
    step();
    fetch(16'hFFF8);
    check("s3_vec", Intvector, 16'h1230);
    bus_write(3'd7, 8'h00);
    peek("s3_pend_kept", 3'd0, 8'h01);
    bus_write(3'd0, 8'h01);
    peek("s3_w1c", 3'd0, 8'h00);
    bus_write(3'd6, 8'h02);
    SRC = 8'h02;
    step(); step();
    bus_write(3'd0, 8'h02);
    peek("s3_set_wins", 3'd0, 8'h02);
    SRC = 8'h00;

    // Spurious acknowledge
    do_reset();
    bus_write(3'd6, 8'hFF);
    fetch(16'hFFF8);
    check("s4_vec", Intvector, 16'hFFFE);
    peek("s4_act", 3'd5, 8'h07);
    fetch(16'hFFF9);
    peek("s4_pend", 3'd0, 8'hFF);

    // NMI pulse length
    do_reset();
    NMI_REQ = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      step();
      check($sformatf("nmi_k%0d", k), 16'(nNMI), 16'(!(k >= 4 && k <= 11)));
    end

    // NMI retrigger five cycles after the first load
    do_reset();
    NMI_REQ = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      check($sformatf("nmi_rt_k%0d", k), 16'(nNMI), 16'(!(k >= 4 && k <= 16)));
      if (k == 2) NMI_REQ = 1'b0;
      if (k == 5) NMI_REQ = 1'b1;
    end

    // Reset between the two acknowledge cycles
    do_reset();
    bus_write(3'd1, 8'hFF);
    bus_write(3'd6, 8'h08);
    step();
    check("s6_nirq", 16'(nIRQ), 16'h0);
    fetch(16'hFFF8);
    check("s6_vec", Intvector, 16'hFFF6);
    RESET = 1'b1;
    #1;
    check("s6_rst_vec", Intvector, 16'hFFF0);
    check("s6_rst_nirq", 16'(nIRQ), 16'h1);
    RESET = 1'b0;
    SRC = 8'h08;
    step(); step(); step();
    SRC = 8'h00;
    peek("s6_pend_set", 3'd0, 8'h08);
    fetch(16'hFFF9);
    peek("s6_pend_kept", 3'd0, 8'h08);

    // Randomized run against the model
    do_reset();
    m_pend = 8'h00; m_mask = 8'h00; m_fsel = 8'h00; m_vbh = 8'hFF; m_vbl = 8'hF0;
    m_act = 8'h00; m_ivec = 16'hFFF0; m_nirq = 1'b1; m_nfirq = 1'b1; m_nnmi = 1'b1;
    m_hold = 0; m_hid = 7; m_hval = 1'b0; last_load = 0;
    src_at[0] = 8'h00; nmi_at[0] = 1'b0;
    prev_op = 0;
    for (int c = 1; c <= NCYC; c++) begin
      if ($urandom_range(0, 5) == 0) begin
        idx = $urandom_range(0, 7);
        SRC[idx] = ~SRC[idx];
      end
      if ($urandom_range(0, 11) == 0) NMI_REQ = ~NMI_REQ;
      op = $urandom_range(0, 10);
      if (prev_op == 6 && $urandom_range(0, 1) == 1) op = 8;
      if (prev_op == 7 && $urandom_range(0, 1) == 1) op = 9;
      bus_idle();
      ADDR = 16'($urandom);
      roff = 3'($urandom_range(0, 7));
      case (op)
        4: begin
          CYC = 1'b1; RnW = 1'b0; ADDR = BASE + 16'(roff); DIN = 8'($urandom);
        end
        5: begin
          CYC = 1'b1; RnW = 1'b1; ADDR = BASE + 16'(roff);
          #1;
          check("rnd_dout", 16'(DOUT), 16'(mread(roff)));
          check("rnd_dsel", 16'(DSEL), 16'h1);
        end
        6, 7, 8, 9, 10: begin
          CYC = 1'b1; RnW = 1'b1; BS = 1'b1; BA = 1'b0;
          case (op)
            6:       ADDR = 16'hFFF8;
            7:       ADDR = 16'hFFF6;
            8:       ADDR = 16'hFFF9;
            9:       ADDR = 16'hFFF7;
            default: ADDR = 16'hFFFE;
          endcase
        end
        default: ;
      endcase
      src_at[c] = SRC;
      nmi_at[c] = NMI_REQ;
      model_edge(c);
      step();
      check("rnd_nirq", 16'(nIRQ), 16'(m_nirq));
      check("rnd_nfirq", 16'(nFIRQ), 16'(m_nfirq));
      check("rnd_nnmi", 16'(nNMI), 16'(m_nnmi));
      check("rnd_vec", Intvector, m_ivec);
      prev_op = op;
    end
    bus_idle();
    peek("rnd_pend_end", 3'd0, m_pend);
    peek("rnd_act_end", 3'd5, m_act);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
